// File: rtl/vram_arbiter_pkg.sv
// Shared types and defaults for the VRAM arbiter: FSM state, read-owner tags, wait default.
package vram_arbiter_pkg;

    localparam int unsigned MpuWaitMaxDefault = 8;

    typedef enum logic [1:0] {
        StShared = 2'd0,
        StDrain  = 2'd1,
        StMpuOwn = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        TagNone = 2'd0,
        TagMpu  = 2'd1,
        TagRen  = 2'd2
    } owner_tag_e;

endpackage

// File: rtl/vram_arbiter.sv
// Two-requester VRAM arbiter (MPU + renderer) with registered command outputs and a
// one-entry owner tag that routes read data back two cycles after the grant.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 20,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned MPU_WAIT_MAX = MpuWaitMaxDefault
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mpu_own,
    input  logic                  mpu_req,
    input  logic                  mpu_wr,
    input  logic [1:0]            mpu_be,
    input  logic [ADDR_WIDTH-1:0] mpu_addr,
    input  logic [DATA_WIDTH-1:0] mpu_wdata,
    output logic                  mpu_ack,
    output logic                  mpu_rvalid,
    output logic [DATA_WIDTH-1:0] mpu_rdata,
    input  logic                  ren_req,
    input  logic [ADDR_WIDTH-1:0] ren_addr,
    output logic                  ren_ack,
    output logic                  ren_rvalid,
    output logic [DATA_WIDTH-1:0] ren_rdata,
    output logic                  vram_en,
    output logic                  vram_rd,
    output logic                  vram_wr,
    output logic [1:0]            vram_be,
    output logic [ADDR_WIDTH-1:0] vram_addr,
    output logic [DATA_WIDTH-1:0] vram_data_out,
    input  logic [DATA_WIDTH-1:0] vram_data_in
);

    localparam int unsigned WaitW = $clog2(MPU_WAIT_MAX + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MPU_WAIT_MAX);

    arb_state_e state_q, state_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic grant_mpu, grant_ren;

    owner_tag_e tag_q, tag_d;
    logic en_q, en_d, rd_q, rd_d, wr_q, wr_d;
    logic [1:0] be_q, be_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic mpu_ack_q, ren_ack_q;
    logic mpu_rvalid_q, ren_rvalid_q;
    logic [DATA_WIDTH-1:0] mpu_rdata_q, ren_rdata_q;

    // Grant decision; an ownership change costs this cycle and one DRAIN cycle with no grant.
    always_comb begin
        state_d   = state_q;
        grant_mpu = 1'b0;
        grant_ren = 1'b0;
        unique case (state_q)
            StShared: begin
                if (mpu_own) begin
                    state_d = StDrain;
                end else if (mpu_req && (!ren_req || wait_cnt_q == WaitMax)) begin
                    grant_mpu = 1'b1;
                end else if (ren_req) begin
                    grant_ren = 1'b1;
                end
            end
            StDrain: begin
                state_d = mpu_own ? StMpuOwn : StShared;
            end
            StMpuOwn: begin
                if (!mpu_own) begin
                    state_d = StDrain;
                end else if (mpu_req) begin
                    grant_mpu = 1'b1;
                end
            end
            default: state_d = StShared;
        endcase
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q != StShared || state_d != StShared) begin
            wait_cnt_d = '0;
        end else if (grant_mpu || !mpu_req) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WaitMax) begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
    end

    // Next command; the address holds through idle cycles.
    always_comb begin
        en_d   = 1'b0;
        rd_d   = 1'b0;
        wr_d   = 1'b0;
        be_d   = 2'b00;
        addr_d = addr_q;
        dout_d = '0;
        tag_d  = TagNone;
        if (grant_mpu) begin
            en_d   = 1'b1;
            rd_d   = !mpu_wr;
            wr_d   = mpu_wr;
            be_d   = mpu_be;
            addr_d = mpu_addr;
            dout_d = mpu_wr ? mpu_wdata : '0;
            tag_d  = mpu_wr ? TagNone : TagMpu;
        end else if (grant_ren) begin
            en_d   = 1'b1;
            rd_d   = 1'b1;
            be_d   = 2'b11;
            addr_d = ren_addr;
            tag_d  = TagRen;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StShared;
            wait_cnt_q   <= '0;
            tag_q        <= TagNone;
            en_q         <= 1'b0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            be_q         <= 2'b00;
            addr_q       <= '0;
            dout_q       <= '0;
            mpu_ack_q    <= 1'b0;
            ren_ack_q    <= 1'b0;
            mpu_rvalid_q <= 1'b0;
            ren_rvalid_q <= 1'b0;
            mpu_rdata_q  <= '0;
            ren_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            tag_q        <= tag_d;
            en_q         <= en_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            be_q         <= be_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            mpu_ack_q    <= grant_mpu;
            ren_ack_q    <= grant_ren;
            // vram_data_in belongs to the command driven this cycle, tagged by tag_q.
            mpu_rvalid_q <= (tag_q == TagMpu);
            ren_rvalid_q <= (tag_q == TagRen);
            if (tag_q == TagMpu) begin
                mpu_rdata_q <= vram_data_in;
            end
            if (tag_q == TagRen) begin
                ren_rdata_q <= vram_data_in;
            end
        end
    end

    assign vram_en       = en_q;
    assign vram_rd       = rd_q;
    assign vram_wr       = wr_q;
    assign vram_be       = be_q;
    assign vram_addr     = addr_q;
    assign vram_data_out = dout_q;
    assign mpu_ack       = mpu_ack_q;
    assign ren_ack       = ren_ack_q;
    assign mpu_rvalid    = mpu_rvalid_q;
    assign ren_rvalid    = ren_rvalid_q;
    assign mpu_rdata     = mpu_rdata_q;
    assign ren_rdata     = ren_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: acks push expected read data, a monitor checks rvalids.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        mpu_own, mpu_req, mpu_wr;
    logic [1:0]  mpu_be;
    logic [19:0] mpu_addr;
    logic [15:0] mpu_wdata;
    logic        mpu_ack, mpu_rvalid;
    logic [15:0] mpu_rdata;
    logic        ren_req;
    logic [19:0] ren_addr;
    logic        ren_ack, ren_rvalid;
    logic [15:0] ren_rdata;
    logic        vram_en, vram_rd, vram_wr;
    logic [1:0]  vram_be;
    logic [19:0] vram_addr;
    logic [15:0] vram_data_out, vram_data_in;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;
    exp_t mpu_q[$];
    exp_t ren_q[$];

    vram_arbiter #(
        .ADDR_WIDTH  (20),
        .DATA_WIDTH  (16),
        .MPU_WAIT_MAX(8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mpu_own      (mpu_own),
        .mpu_req      (mpu_req),
        .mpu_wr       (mpu_wr),
        .mpu_be       (mpu_be),
        .mpu_addr     (mpu_addr),
        .mpu_wdata    (mpu_wdata),
        .mpu_ack      (mpu_ack),
        .mpu_rvalid   (mpu_rvalid),
        .mpu_rdata    (mpu_rdata),
        .ren_req      (ren_req),
        .ren_addr     (ren_addr),
        .ren_ack      (ren_ack),
        .ren_rvalid   (ren_rvalid),
        .ren_rdata    (ren_rdata),
        .vram_en      (vram_en),
        .vram_rd      (vram_rd),
        .vram_wr      (vram_wr),
        .vram_be      (vram_be),
        .vram_addr    (vram_addr),
        .vram_data_out(vram_data_out),
        .vram_data_in (vram_data_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] model(input logic [19:0] a);
        return a[15:0] ^ 16'hA5C3 ^ {a[19:16], 12'h000};
    endfunction

    // VRAM model answers only while a read command is on the bus.
    assign vram_data_in = (vram_en && vram_rd) ? model(vram_addr) : 16'hDEAD;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ctl"}, {vram_en, vram_rd, vram_wr, vram_be, mpu_ack, ren_ack,
                             mpu_rvalid, ren_rvalid}, 32'h0);
        chk({name, "_addr"}, vram_addr, 32'h0);
        chk({name, "_dout"}, vram_data_out, 32'h0);
        chk({name, "_rdata"}, {mpu_rdata, ren_rdata}, 32'h0);
    endtask

    function automatic exp_t mk(input logic [19:0] a);
        exp_t e;
        e.data = model(a);
        e.cyc  = cyc;
        return e;
    endfunction

    // Monitor: pop and compare whenever the DUT presents read data.
    always @(negedge clk) begin
        exp_t e;
        if (mpu_ack || ren_ack) chk("single_ack", {mpu_ack, ren_ack} == 2'b11, 1'b0);
        if (mpu_rvalid) begin
            if (mpu_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mpu_rvalid_unexpected: got rvalid expected none (cycle %0d)", cyc);
            end else begin
                e = mpu_q.pop_front();
                chk("mpu_rdata", mpu_rdata, e.data);
                chk("mpu_rvalid_lat", cyc, e.cyc + 1);
            end
        end
        if (ren_rvalid) begin
            if (ren_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ren_rvalid_unexpected: got rvalid expected none (cycle %0d)", cyc);
            end else begin
                e = ren_q.pop_front();
                chk("ren_rdata", ren_rdata, e.data);
                chk("ren_rvalid_lat", cyc, e.cyc + 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int idx;
        int mpu_lat;
        reset = 1'b1; mpu_own = 1'b0; mpu_req = 1'b0; mpu_wr = 1'b0; mpu_be = 2'b00;
        mpu_addr = '0; mpu_wdata = '0; ren_req = 1'b0; ren_addr = '0;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        chk_all_zero("post_reset");

        // Renderer stream alone: ack every cycle.
        idx = 0;
        ren_req = 1'b1;
        ren_addr = 20'h00100;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("ren_stream_ack", ren_ack, 1'b1);
            chk("ren_stream_cmd", {vram_en, vram_rd, vram_wr, vram_be}, 5'b11011);
            chk("ren_stream_addr", vram_addr, 20'h00100 + 20'(idx));
            if (ren_ack) begin
                ren_q.push_back(mk(ren_addr));
                idx++;
                ren_addr = 20'h00100 + 20'(idx);
            end
        end
        ren_req = 1'b0;
        repeat (3) @(negedge clk);

        // MPU read against a saturating renderer: granted after the wait limit.
        mpu_lat = 0;
        ren_req = 1'b1; ren_addr = 20'h02000; idx = 0;
        mpu_req = 1'b1; mpu_wr = 1'b0; mpu_be = 2'b11; mpu_addr = 20'h00123;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("starve_mpu_ack", mpu_ack, k == 9);
            chk("starve_ren_ack", ren_ack, k != 9);
            if (mpu_ack) begin
                mpu_lat = k;
                chk("starve_mpu_addr", vram_addr, 20'h00123);
                mpu_q.push_back(mk(mpu_addr));
                mpu_req = 1'b0;
            end
            if (ren_ack) begin
                ren_q.push_back(mk(ren_addr));
                idx++;
                ren_addr = 20'h02000 + 20'(idx);
            end
        end
        chk("starve_mpu_latency", mpu_lat, 9);
        ren_req = 1'b0;
        repeat (3) @(negedge clk);

        // MPU write: one write cycle, then idle bus with held address, no rvalid.
        mpu_req = 1'b1; mpu_wr = 1'b1; mpu_be = 2'b01; mpu_addr = 20'h00010;
        mpu_wdata = 16'hBEEF;
        @(negedge clk);
        chk("wr_ack", mpu_ack, 1'b1);
        chk("wr_cmd", {vram_en, vram_rd, vram_wr, vram_be}, 5'b10101);
        chk("wr_addr", vram_addr, 20'h00010);
        chk("wr_dout", vram_data_out, 16'hBEEF);
        mpu_req = 1'b0; mpu_wr = 1'b0;
        @(negedge clk);
        chk("wr_idle_cmd", {vram_en, vram_rd, vram_wr, vram_be}, 5'b00000);
        chk("wr_idle_addr_hold", vram_addr, 20'h00010);
        chk("wr_idle_dout", vram_data_out, 16'h0);
        chk("wr_no_rvalid", mpu_rvalid, 1'b0);
        repeat (2) @(negedge clk);

        // Ownership switch with a renderer read in flight.
        ren_req = 1'b1; ren_addr = 20'h00400;
        @(negedge clk);
        chk("own_ren_ack", ren_ack, 1'b1);
        ren_q.push_back(mk(ren_addr));
        ren_addr = 20'h00401;
        mpu_own = 1'b1;
        mpu_req = 1'b1; mpu_wr = 1'b0; mpu_be = 2'b11; mpu_addr = 20'h00200;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("drain_no_ack", {mpu_ack, ren_ack}, 2'b00);
        end
        @(negedge clk);
        chk("own_mpu_ack0", {mpu_ack, ren_ack}, 2'b10);
        mpu_q.push_back(mk(mpu_addr));
        mpu_addr = 20'h00201;
        @(negedge clk);
        chk("own_mpu_ack1", {mpu_ack, ren_ack}, 2'b10);
        mpu_q.push_back(mk(mpu_addr));
        mpu_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("own_ren_ignored", ren_ack, 1'b0);
        end
        mpu_own = 1'b0; ren_req = 1'b0;
        repeat (4) @(negedge clk);

        // Reset right after an MPU read ack discards the read.
        mpu_req = 1'b1; mpu_wr = 1'b0; mpu_be = 2'b11; mpu_addr = 20'h00300;
        @(negedge clk);
        chk("rst_mpu_ack", mpu_ack, 1'b1);
        mpu_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("mid_reset");
        reset = 1'b0;
        @(negedge clk);
        chk_all_zero("after_mid_reset");
        ren_req = 1'b1; ren_addr = 20'h00500;
        @(negedge clk);
        chk("rst_shared_ren_ack", ren_ack, 1'b1);
        ren_q.push_back(mk(ren_addr));
        ren_req = 1'b0;
        repeat (3) @(negedge clk);

        chk("mpu_q_drained", mpu_q.size(), 0);
        chk("ren_q_drained", ren_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
